// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(7,4) UART receive path.
// Holds the receiver FSM state encoding, the Hamming code bit positions
// (index i holds Hamming position i+1) and the 8N1 frame constants.
package hamming_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_DECODE    = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  // Code word layout: code = {d3,d2,d1,p4,d0,p2,p1}
  localparam int CODE_W = 7;
  localparam int P1     = 0;
  localparam int P2     = 1;
  localparam int D0     = 2;
  localparam int P4     = 3;
  localparam int D1     = 4;
  localparam int D2     = 5;
  localparam int D3     = 6;

  // UART byte layout: {pad, code[6:0]}
  localparam int DATA_BITS = 8;
  localparam int PAD_BIT   = 7;

endpackage

// File: rtl/hamming74_decode.sv
// Combinational Hamming(7,4) decoder with single-bit error correction.
// Ports:
//   code      in  7  received code word {d3,d2,d1,p4,d0,p2,p1}
//   data      out 4  corrected nibble {d3,d2,d1,d0}
//   syndrome  out 3  raw syndrome {s4,s2,s1}; value = position of the bad bit
//   corrected out 1  syndrome nonzero, one code bit was flipped
// Two-bit errors produce a nonzero syndrome and are miscorrected; nothing
// here can tell them apart from single-bit errors.
module hamming74_decode
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [3:0]        data,
  output logic [2:0]        syndrome,
  output logic              corrected
);

  logic [CODE_W-1:0] fixed;

  // NOTE: every signal assigned in a combinational block gets a value on
  // every path (here, unconditionally); a missing assignment infers a latch.
  always_comb begin
    syndrome[0] = code[P1] ^ code[D0] ^ code[D1] ^ code[D3];
    syndrome[1] = code[P2] ^ code[D0] ^ code[D2] ^ code[D3];
    syndrome[2] = code[P4] ^ code[D1] ^ code[D2] ^ code[D3];
    corrected   = |syndrome;

    // Syndrome names the 1-based position in error; flip exactly that bit.
    for (int i = 0; i < CODE_W; i++) begin
      fixed[i] = code[i] ^ (syndrome == 3'(i + 1));
    end

    data = {fixed[D3], fixed[D2], fixed[D1], fixed[D0]};
  end

endmodule

// File: rtl/uart_hamming_rx.sv
// 8N1 UART receiver that decodes each byte {pad, code[6:0]} as a
// Hamming(7,4) code word and delivers the corrected nibble.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   rx          asynchronous serial input, idles high
//   data_out    corrected nibble, held until the next good frame
//   data_valid  one-cycle pulse when data_out/corrected/syndrome/pad_err update
//   corrected   last frame had a nonzero syndrome
//   syndrome    last frame's raw syndrome {s4,s2,s1}
//   pad_err     last frame had byte bit 7 set (nibble still delivered)
//   frame_err   one-cycle pulse when the stop bit is sampled low
//   rx_busy     high whenever the receiver is not idle
module uart_hamming_rx
  import hamming_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [3:0] data_out,
  output logic       data_valid,
  output logic       corrected,
  output logic [2:0] syndrome,
  output logic       pad_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]        LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 corrected_q, corrected_d;
  logic [2:0]           syndrome_q, syndrome_d;
  logic                 pad_err_q, pad_err_d;
  logic                 frame_err_q, frame_err_d;

  logic [3:0]           dec_data;
  logic [2:0]           dec_syndrome;
  logic                 dec_corrected;

  hamming74_decode u_decode (
    .code      (shift_q[CODE_W-1:0]),
    .data      (dec_data),
    .syndrome  (dec_syndrome),
    .corrected (dec_corrected)
  );

  // State register. The synchroniser resets to 1 so a reset never looks
  // like a start bit.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Next-state logic. All line sampling uses the synchronised rx_s_q.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (!rx_s_q) state_d = ST_START;
      ST_START:     if (cnt_q == HALF_M1) state_d = rx_s_q ? ST_IDLE : ST_DATA;
      ST_DATA:      if (cnt_q == FULL_M1 && bit_idx_q == LAST_BIT) state_d = ST_STOP;
      ST_STOP:      if (cnt_q == FULL_M1) state_d = rx_s_q ? ST_DECODE : ST_WAIT_IDLE;
      ST_DECODE:    state_d = ST_IDLE;
      // A held-low line (break) parks here instead of retriggering a frame.
      ST_WAIT_IDLE: if (rx_s_q) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Datapath: counters, shift register and result registers.
  always_comb begin
    cnt_d        = cnt_q + CNT_ONE;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    corrected_d  = corrected_q;
    syndrome_d   = syndrome_q;
    pad_err_d    = pad_err_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: cnt_d = '0;
      ST_START: begin
        // Mid start bit: the data bit centres are whole bit-times from here.
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d        = bit_idx_q + 3'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == FULL_M1 && !rx_s_q) frame_err_d = 1'b1;
      end
      ST_DECODE: begin
        data_valid_d = 1'b1;
        data_out_d   = dec_data;
        corrected_d  = dec_corrected;
        syndrome_d   = dec_syndrome;
        pad_err_d    = shift_q[PAD_BIT];
      end
      ST_WAIT_IDLE: cnt_d = '0;
      default:      cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      corrected_q  <= 1'b0;
      syndrome_q   <= '0;
      pad_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      corrected_q  <= corrected_d;
      syndrome_q   <= syndrome_d;
      pad_err_q    <= pad_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Output logic.
  always_comb begin
    rx_busy    = (state_q != ST_IDLE);
    data_out   = data_out_q;
    data_valid = data_valid_q;
    corrected  = corrected_q;
    syndrome   = syndrome_q;
    pad_err    = pad_err_q;
    frame_err  = frame_err_q;
  end

endmodule

// File: tb/tb_uart_hamming_rx.sv
// Scoreboard bench for uart_hamming_rx: stimulus pushes the expected decode
// of each byte into a queue; a monitor pops and compares on each data_valid.
module tb_uart_hamming_rx;

  localparam int CLKS = 16;

  typedef struct packed {
    logic [3:0] data;
    logic       corr;
    logic [2:0] syn;
    logic       pad;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [3:0] data_out;
  logic       data_valid;
  logic       corrected;
  logic [2:0] syndrome;
  logic       pad_err;
  logic       frame_err;
  logic       rx_busy;

  exp_t       exp_q[$];
  int         n_vec   = 0;
  int         n_err   = 0;
  int         exp_fe  = 0;
  int         seen_fe = 0;
  logic [3:0] last_data = 4'h0;
  logic       prev_dv = 1'b0;
  logic       prev_fe = 1'b0;

  uart_hamming_rx #(.CLKS_PER_BIT(CLKS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .corrected  (corrected),
    .syndrome   (syndrome),
    .pad_err    (pad_err),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the syndrome of a Hamming code is the XOR of the 1-based
  // positions of all set bits; flip that position, then read the data slots.
  function automatic exp_t model(input logic [7:0] b);
    exp_t       r;
    int         syn;
    logic [6:0] c;
    syn = 0;
    c   = b[6:0];
    for (int i = 0; i < 7; i++) if (c[i]) syn = syn ^ (i + 1);
    if (syn != 0) c[syn - 1] = ~c[syn - 1];
    r.data = {c[6], c[5], c[4], c[2]};
    r.corr = (syn != 0);
    r.syn  = 3'(syn);
    r.pad  = b[7];
    return r;
  endfunction

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) exp_q.push_back(model(b));
    else exp_fe++;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"},   32'(data_out),   32'h0);
    check({tag, "_data_valid"}, 32'(data_valid), 32'h0);
    check({tag, "_corrected"},  32'(corrected),  32'h0);
    check({tag, "_syndrome"},   32'(syndrome),   32'h0);
    check({tag, "_pad_err"},    32'(pad_err),    32'h0);
    check({tag, "_frame_err"},  32'(frame_err),  32'h0);
    check({tag, "_rx_busy"},    32'(rx_busy),    32'h0);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_dv = 1'b0;
      prev_fe = 1'b0;
    end else begin
      if (data_valid) begin
        check("dv_single_cycle", 32'(prev_dv), 32'h0);
        if (exp_q.size() == 0) begin
          check("unexpected_data_valid", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("data_out",  32'(data_out),  32'(e.data));
          check("corrected", 32'(corrected), 32'(e.corr));
          check("syndrome",  32'(syndrome),  32'(e.syn));
          check("pad_err",   32'(pad_err),   32'(e.pad));
          last_data = e.data;
        end
      end
      if (frame_err) begin
        check("fe_single_cycle", 32'(prev_fe), 32'h0);
        check("fe_without_dv", 32'(data_valid), 32'h0);
        seen_fe++;
      end
      prev_dv = data_valid;
      prev_fe = frame_err;
    end
  end

  initial begin
    int polls;
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    drive_bit(1'b1);

    // Directed frames: clean, single-bit errors, pad bit set.
    send_frame(8'h55, 1'b1); drive_bit(1'b1);
    send_frame(8'h45, 1'b1); drive_bit(1'b1);
    send_frame(8'h01, 1'b1); drive_bit(1'b1);
    send_frame(8'hD5, 1'b1); drive_bit(1'b1);
    check("directed_drained", 32'(exp_q.size()), 32'h0);

    // Bad stop bit followed by a 3 bit-time break.
    send_frame(8'h55, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_bit(1'b0);
      check("busy_during_break", 32'(rx_busy), 32'h1);
    end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check("busy_after_break", 32'(rx_busy), 32'h0);
    check("frame_err_count", 32'(seen_fe), 32'(exp_fe));
    check("data_held_after_fe", 32'(data_out), 32'(last_data));
    drive_bit(1'b1);
    drive_bit(1'b1);

    // Short low glitch: false start, no pulses, receiver back to idle.
    rx = 1'b0;
    repeat (CLKS / 4) @(negedge clk);
    rx = 1'b1;
    polls = 0;
    repeat (3) @(negedge clk);
    while (rx_busy && polls < CLKS / 2 + 3) begin
      @(negedge clk);
      polls++;
    end
    check("glitch_busy_clears", 32'(rx_busy), 32'h0);
    drive_bit(1'b1);

    // Back-to-back frames, then reset in the middle of a third frame.
    send_frame(8'h55, 1'b1);
    send_frame(8'h00, 1'b1);
    check("b2b_drained", 32'(exp_q.size()), 32'h0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("midframe_reset");
    rx = 1'b1;
    last_data = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    check_all_zero("after_reset");
    send_frame(8'h55, 1'b1);
    drive_bit(1'b1);

    // Randomised frames with random idle gaps (including none).
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      int         gap;
      b   = 8'($urandom);
      gap = $urandom_range(0, 20);
      send_frame(b, 1'b1);
      rx = 1'b1;
      repeat (gap) @(negedge clk);
    end

    repeat (2 * CLKS) @(negedge clk);
    check("final_drained", 32'(exp_q.size()), 32'h0);
    check("final_frame_err_count", 32'(seen_fe), 32'(exp_fe));
    check("final_idle", 32'(rx_busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
